// File: rtl/spi_flash_burst_reader.sv
// ============================================================================
// Module   : spi_flash_burst_reader
// Brief    : SPI mode-0 flash burst read master (READ 0x03, or FAST READ 0x0B
//            with SPI_FAST_READ_EN defined), 1..MAX_BURST bytes per request.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_flash_burst_reader #(
    parameter  int ADDR_BYTES = 3,
    parameter  int CLK_DIV    = 2,
    parameter  int MAX_BURST  = 16,
    localparam int LEN_W      = $clog2(MAX_BURST + 1)
) (
    input  logic                    clk,
    input  logic                    i_RESET,
    input  logic                    i_START,
    input  logic [8*ADDR_BYTES-1:0] i_ADDRESS,
    input  logic [LEN_W-1:0]        i_LEN,
    input  logic                    i_SPI_MISO,
    output logic                    o_SPI_CLK,
    output logic                    o_SPI_MOSI,
    output logic                    o_SPI_CS,
    output logic [7:0]              o_DATA,
    output logic                    o_VALID,
    output logic                    o_BUSY,
    output logic                    o_DONE
);

    localparam int              TX_W        = 8 + 8*ADDR_BYTES;
    localparam int              DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [5:0]      c_ADDR_LAST = 6'(8*ADDR_BYTES - 1);
`ifdef SPI_FAST_READ_EN
    localparam logic [7:0]      c_CMD       = 8'h0B;
`else
    localparam logic [7:0]      c_CMD       = 8'h03;
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_ADDR    = 3'd2,
`ifdef SPI_FAST_READ_EN
        S_DUMMY   = 3'd3,
`endif
        S_DATA    = 3'd4,
        S_TAIL    = 3'd5,
        S_RECOVER = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [DIV_W-1:0]   r_div;
    logic               r_sck;
    logic               r_mosi;
    logic [TX_W-1:0]    r_tx;
    logic [7:0]         r_rx;
    logic [7:0]         r_data;
    logic               r_valid;
    logic               r_done;
    logic               r_byte_ready;
    logic [5:0]         r_bit_cnt;
    logic [LEN_W-1:0]   r_len;

    logic               w_div_last;
    logic               w_shifting;
    logic               w_rise;
    logic               w_bit_end;
    logic               w_last_bit;
    logic               w_accept;
    logic [LEN_W-1:0]   w_len_cap;

    assign w_div_last = (r_div == c_DIV_LAST);
    assign w_rise     = w_shifting && !r_sck && w_div_last;
    assign w_bit_end  = w_shifting &&  r_sck && w_div_last;
    assign w_last_bit = (r_bit_cnt == 6'd0);
    assign w_accept   = (r_state == S_IDLE) && i_START;

    always_comb begin
        w_shifting = 1'b0;
        case (r_state)
            S_CMD, S_ADDR, S_DATA: w_shifting = 1'b1;
`ifdef SPI_FAST_READ_EN
            S_DUMMY:               w_shifting = 1'b1;
`endif
            default:               w_shifting = 1'b0;
        endcase
    end

    always_comb begin
        w_len_cap = i_LEN;
        if (i_LEN == '0)
            w_len_cap = LEN_W'(1);
        else if (i_LEN > LEN_W'(MAX_BURST))
            w_len_cap = LEN_W'(MAX_BURST);
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (i_START)                 w_next_state = S_CMD;
            S_CMD:     if (w_bit_end && w_last_bit) w_next_state = S_ADDR;
`ifdef SPI_FAST_READ_EN
            S_ADDR:    if (w_bit_end && w_last_bit) w_next_state = S_DUMMY;
            S_DUMMY:   if (w_bit_end && w_last_bit) w_next_state = S_DATA;
`else
            S_ADDR:    if (w_bit_end && w_last_bit) w_next_state = S_DATA;
`endif
            S_DATA:    if (w_bit_end && w_last_bit && (r_len == LEN_W'(1)))
                                                    w_next_state = S_TAIL;
            S_TAIL:    if (w_div_last)              w_next_state = S_RECOVER;
            S_RECOVER: if (w_div_last)              w_next_state = S_IDLE;
            default:                                w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_RESET)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (i_RESET) begin
            r_div        <= '0;
            r_sck        <= 1'b0;
            r_mosi       <= 1'b0;
            r_tx         <= '0;
            r_rx         <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_done       <= 1'b0;
            r_byte_ready <= 1'b0;
            r_bit_cnt    <= '0;
            r_len        <= '0;
        end else begin
            r_done       <= 1'b0;
            r_valid      <= r_byte_ready;
            r_byte_ready <= 1'b0;
            if (r_byte_ready)
                r_data <= r_rx;

            if (w_accept) begin
                // First command bit goes out with CS; r_tx holds the bits after it.
                r_div     <= '0;
                r_sck     <= 1'b0;
                r_mosi    <= c_CMD[7];
                r_tx      <= {c_CMD[6:0], i_ADDRESS, 1'b0};
                r_bit_cnt <= 6'd7;
                r_len     <= w_len_cap;
            end else if (r_state != S_IDLE) begin
                r_div <= w_div_last ? '0 : r_div + 1'b1;

                if (w_rise) begin
                    r_sck <= 1'b1;
                    if (r_state == S_DATA) begin
                        r_rx         <= {r_rx[6:0], i_SPI_MISO};
                        r_byte_ready <= w_last_bit;
                    end
                end

                if (w_bit_end) begin
                    r_sck  <= 1'b0;
                    r_tx   <= r_tx << 1;
                    r_mosi <= ((w_next_state == S_CMD) || (w_next_state == S_ADDR))
                              ? r_tx[TX_W-1] : 1'b0;
                    if (!w_last_bit)
                        r_bit_cnt <= r_bit_cnt - 6'd1;
                    else if (w_next_state == S_ADDR)
                        r_bit_cnt <= c_ADDR_LAST;
                    else
                        r_bit_cnt <= 6'd7;
                    if ((r_state == S_DATA) && w_last_bit)
                        r_len <= r_len - 1'b1;
                end

                if ((r_state == S_TAIL) && w_div_last)
                    r_done <= 1'b1;
            end
        end
    end

    assign o_SPI_CLK  = r_sck;
    assign o_SPI_MOSI = r_mosi;
    assign o_SPI_CS   = (r_state == S_IDLE) || (r_state == S_RECOVER);
    assign o_BUSY     = (r_state != S_IDLE);
    assign o_DATA     = r_data;
    assign o_VALID    = r_valid;
    assign o_DONE     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_spi_flash_burst_reader.sv
// ============================================================================
// Module   : tb_spi_flash_burst_reader
// Brief    : Self-checking bench with a behavioural SPI flash and transaction
//            model for spi_flash_burst_reader (honours SPI_FAST_READ_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_flash_burst_reader;

    localparam int AB  = 3;
    localparam int CD  = 2;
    localparam int MB  = 16;
    localparam int LW  = $clog2(MB + 1);
`ifdef SPI_FAST_READ_EN
    localparam int         DM  = 8;
    localparam logic [7:0] CMD = 8'h0B;
`else
    localparam int         DM  = 0;
    localparam logic [7:0] CMD = 8'h03;
`endif
    localparam int HDR = 8 + 8*AB + DM;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [8*AB-1:0] addr = '0;
    logic [LW-1:0]   len = '0;
    logic            miso = 1'b0;
    logic            sck, mosi, cs, valid, busy, done;
    logic [7:0]      data;

    spi_flash_burst_reader #(.ADDR_BYTES(AB), .CLK_DIV(CD), .MAX_BURST(MB)) dut (
        .clk(clk), .i_RESET(rst), .i_START(start), .i_ADDRESS(addr), .i_LEN(len),
        .i_SPI_MISO(miso), .o_SPI_CLK(sck), .o_SPI_MOSI(mosi), .o_SPI_CS(cs),
        .o_DATA(data), .o_VALID(valid), .o_BUSY(busy), .o_DONE(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Flash model state and observation record
    logic [7:0] fbytes [32];
    int         rise_cnt = 0, sck_rises = 0, cs_falls = 0, done_cnt = 0;
    int         done_cyc = 0, busy_cycles = 0, glitches = 0;
    logic       busy_at_done = 1'b0, cs_at_done = 1'b0;
    logic [7:0] rx_q [$];
    int         vcyc_q [$];
    bit         mosi_q [$];

    function automatic logic model_bit(input int r);
        int idx;
        logic [7:0] b;
        if (r < HDR) return 1'($urandom);
        idx = r - HDR;
        if (idx / 8 >= 32) return 1'b0;
        b = fbytes[idx / 8];
        return b[7 - (idx % 8)];
    endfunction

    initial begin
        logic prev_sck, prev_cs, prev_mosi;
        prev_sck = 1'b0; prev_cs = 1'b1; prev_mosi = 1'b0;
        forever begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (!cs && prev_cs) begin
                cs_falls++;
                rise_cnt = 0;
            end else if (!cs && (mosi !== prev_mosi) && !(prev_sck && !sck)) begin
                glitches++;
            end
            if (sck && !prev_sck) begin
                sck_rises++;
                if (!cs) begin
                    mosi_q.push_back(mosi);
                    rise_cnt++;
                end
            end
            miso = model_bit(rise_cnt);
            if (valid) begin
                rx_q.push_back(data);
                vcyc_q.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc     = cyc;
                busy_at_done = busy;
                cs_at_done   = cs;
            end
            prev_sck = sck; prev_cs = cs; prev_mosi = mosi;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int eff_len(input int l);
        if (l == 0) return 1;
        if (l > MB) return MB;
        return l;
    endfunction

    task automatic run_txn(input logic [8*AB-1:0] a_in, input int len_in, input int n,
                           input logic [31:0] seed, input bit hold_start);
        int base_cs, base_rise, base_rx, base_mosi, base_done, base_busy, base_gl;
        int a_cyc, lat, k, errs, nbits;
        logic [7:0] cmd_v;
        logic       eb;
        cmd_v     = CMD;
        base_cs   = cs_falls;  base_rise = sck_rises; base_rx = rx_q.size();
        base_mosi = mosi_q.size(); base_done = done_cnt; base_busy = busy_cycles;
        base_gl   = glitches;
        for (int i = 0; i < 32; i++)
            fbytes[i] = (i < 4) ? seed[31 - 8*i -: 8] : 8'($urandom);
        addr  = a_in;
        len   = LW'(len_in);
        start = 1'b1;
        a_cyc = cyc;
        step();
        if (!hold_start) start = 1'b0;
        k = 0;
        while (done_cnt == base_done && k < 5000) begin
            step();
            k++;
        end
        start = 1'b0;
        check("done_seen", done_cnt - base_done, 1);
        if (done_cnt == base_done) return;
        lat = done_cyc - a_cyc;
        check("latency", lat, 1 + 2*CD*(HDR + 8*n) + CD);
        check("cs_at_done", cs_at_done, 1);
        check("busy_at_done", busy_at_done, 1);
        while (cyc < done_cyc + CD) step();
        check("busy_end", busy, 0);
        check("busy_cycles", busy_cycles - base_busy, lat + CD - 1);
        check("byte_count", rx_q.size() - base_rx, n);
        for (int i = 0; i < n && base_rx + i < rx_q.size(); i++)
            check($sformatf("byte%0d", i), rx_q[base_rx + i], fbytes[i]);
        if (rx_q.size() > base_rx) begin
            check("first_valid", vcyc_q[base_rx] - a_cyc, 2*CD*(HDR + 7) + CD + 2);
            for (int i = base_rx + 1; i < rx_q.size(); i++)
                check("valid_gap", vcyc_q[i] - vcyc_q[i-1], 16*CD);
        end
        nbits = HDR + 8*n;
        check("sck_rises", sck_rises - base_rise, nbits);
        check("mosi_count", mosi_q.size() - base_mosi, nbits);
        errs = 0;
        for (int r = 0; r < nbits && base_mosi + r < mosi_q.size(); r++) begin
            if (r < 8)           eb = cmd_v[7 - r];
            else if (r < 8+8*AB) eb = a_in[8*AB - 1 - (r - 8)];
            else                 eb = 1'b0;
            if (mosi_q[base_mosi + r] != eb) errs++;
        end
        check("mosi_bits", errs, 0);
        check("cs_assertions", cs_falls - base_cs, 1);
        check("mosi_glitches", glitches - base_gl, 0);
    endtask

    typedef struct {
        logic [8*AB-1:0] addr;
        int              len;
        int              exp_n;
        logic [31:0]     seed;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int base_rx, base_done, base_cs, k, l;

        vecs[0] = '{24'h001234,  1,  1, 32'hA5000000};
        vecs[1] = '{24'hABCDEF,  4,  4, 32'h11223344};
        vecs[2] = '{24'h000000,  0,  1, 32'h5A000000};
        vecs[3] = '{24'hFFFFFF, 31, 16, 32'hDEADBEEF};
        vecs[4] = '{24'h555555, 16, 16, 32'h01020304};
        vecs[5] = '{24'h800100, 17, 16, 32'hF00FCAFE};

        repeat (3) step();
        check("rst_cs", cs, 1);
        check("rst_sck", sck, 0);
        check("rst_mosi", mosi, 0);
        check("rst_data", data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        repeat (2) step();

        for (int v = 0; v < 6; v++) begin
            run_txn(vecs[v].addr, vecs[v].len, vecs[v].exp_n, vecs[v].seed, 1'b0);
            repeat (2) step();
        end

        for (int v = 0; v < 6; v++) begin
            l = $urandom_range(0, 31);
            run_txn(24'($urandom), l, eff_len(l), $urandom, 1'b0);
            repeat ($urandom_range(0, 3)) step();
        end

        // START held high through the whole transaction must not re-trigger
        run_txn(24'h0A0B0C, 2, 2, 32'h6699AA55, 1'b1);
        repeat (3) step();

        // Reset after the second byte of a four-byte burst
        base_rx = rx_q.size(); base_done = done_cnt;
        for (int i = 0; i < 32; i++) fbytes[i] = 8'($urandom);
        addr = 24'h123456; len = LW'(4); start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (rx_q.size() - base_rx < 2 && k < 5000) begin
            step();
            k++;
        end
        check("midrst_two_bytes", rx_q.size() - base_rx, 2);
        rst = 1'b1;
        step();
        check("midrst_cs", cs, 1);
        check("midrst_sck", sck, 0);
        check("midrst_mosi", mosi, 0);
        check("midrst_busy", busy, 0);
        check("midrst_valid", valid, 0);
        check("midrst_data", data, 8'h00);
        step();
        rst = 1'b0;
        repeat (200) step();
        check("midrst_no_more_bytes", rx_q.size() - base_rx, 2);
        check("midrst_no_done", done_cnt - base_done, 0);
        run_txn(24'h00ABCD, 3, 3, 32'h7E8F9A0B, 1'b0);
        repeat (2) step();

        // Reset and START together: reset wins
        base_cs = cs_falls;
        rst = 1'b1; start = 1'b1;
        step();
        rst = 1'b0; start = 1'b0;
        check("rst_start_busy", busy, 0);
        check("rst_start_cs", cs, 1);
        repeat (5) step();
        check("rst_start_no_cs", cs_falls - base_cs, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
